game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
- Top-level game controller for whack-a-mole: sequences each round through idle, 3-2-1 countdown, timed play and game-over hold.
- Gates the game datapath: mole/score logic enable and synchronous clear.
- Owns the round timer and the session high score.
- Consumes the 1 Hz pulse from the existing clock divider; its time_left and score outputs feed bin_to_bcd.

Parameters:
- GAME_SECONDS, 20, length of play phase in sec_pulse ticks (1..255)
- COUNTDOWN_SECONDS, 3, length of pre-game countdown (1..255)
- OVER_HOLD_SECONDS, 5, game-over display hold before auto-return to IDLE (1..255)
- SCORE_BITS, 8, width of score, final_score and high_score

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous reset, active-high
- start  in  1  debounced one-cycle start pulse
- sec_pulse  in  1  one-cycle 1 Hz tick, synchronous to clk
- score  in  SCORE_BITS  live score from game module
- game_srst  out  1  one-cycle synchronous clear to game module
- game_en  out  1  game module enable (moles and scoring active)
- time_left  out  8  value for timer digits
- state  out  2  00 IDLE, 01 COUNTDOWN, 10 PLAY, 11 OVER
- final_score  out  SCORE_BITS  score latched at end of round
- high_score  out  SCORE_BITS  best final_score since reset
- new_high  out  1  high while in OVER if this round set a new high score

Behaviour:
- Reset (async, active-high):
  - state=IDLE; sec_cnt=GAME_SECONDS; hold_cnt=0.
  - game_srst=0, game_en=0, final_score=0, high_score=0, new_high=0.
- All outputs registered except time_left, which is decoded from registers:
  - IDLE: GAME_SECONDS
  - COUNTDOWN, PLAY: sec_cnt
  - OVER: 0
- IDLE:
  - On start: go to COUNTDOWN; sec_cnt<=COUNTDOWN_SECONDS; game_srst<=1 for exactly one cycle.
  - sec_pulse ignored.
- COUNTDOWN:
  - On sec_pulse with sec_cnt>1: sec_cnt decrements.
  - On sec_pulse with sec_cnt==1: go to PLAY; sec_cnt<=GAME_SECONDS; game_en<=1 on the same edge.
  - start ignored.
- PLAY:
  - game_en=1. On sec_pulse, sec_cnt decrements.
  - On sec_pulse with sec_cnt==1 the following happen on the same edge:
    - go to OVER; game_en<=0
    - final_score<=score (value present that cycle)
    - if score>high_score (unsigned): high_score<=score, new_high<=1
    - hold_cnt<=OVER_HOLD_SECONDS
  - start ignored.
- OVER:
  - On sec_pulse, hold_cnt decrements. On sec_pulse with hold_cnt==1: go to IDLE.
  - start in OVER (any cycle): go directly to COUNTDOWN, identical to the IDLE start action. It has priority over a simultaneous sec_pulse.
  - new_high clears on leaving OVER.
- Equal score does not set new_high. high_score persists across rounds, cleared only by reset.
- sec_cnt and hold_cnt never wrap; the ==1 terminal checks make 0 unreachable while counting.
- Reset mid-round: immediate return to reset values, including high_score.
- A start coincident with sec_pulse in IDLE loads the full countdown; the tick is not applied.

Optional Feature:
- Macro PAUSE_EN.
- When defined:
  - Adds input pause_toggle (1-cycle pulse) and output paused (reset 0).
  - pause_toggle in PLAY flips paused.
  - While paused: game_en=0, sec_pulse ignored, sec_cnt frozen.
  - Unpausing restores game_en=1 on the next edge.
  - paused forced 0 on any exit from PLAY.
  - pause_toggle outside PLAY ignored.
- When undefined: ports absent; behaviour as above.

Test Plan:
- Reset, then start, then 3 sec_pulses -> game_srst high exactly 1 cycle after start; time_left 3,2,1; state=PLAY with game_en=1 on the edge of the 3rd pulse; time_left=20.
- In PLAY, 20 sec_pulses with score=12 -> state=OVER, game_en=0 on 20th pulse edge, final_score=12, high_score=12, new_high=1, time_left=0; 5 more pulses -> IDLE, new_high=0.
- Second round with score=12, third with score=9 -> high_score stays 12, new_high=0 both rounds; final_score 12 then 9.
- start pulses during COUNTDOWN and PLAY -> no state change, sec_cnt unaffected; start during OVER coincident with sec_pulse at hold_cnt=1 -> COUNTDOWN, sec_cnt=3, game_srst pulse.
- Assert reset mid-PLAY at time_left=7 with high_score=12 -> all outputs return to reset values asynchronously; high_score=0.
- PAUSE_EN: pause_toggle at time_left=10, 4 sec_pulses, pause_toggle -> time_left stays 10, game_en=0 while paused, then resumes counting from 10.

Source files
------------

// File: rtl/game_sequencer.sv
// game_sequencer: whack-a-mole round controller (idle, countdown, play, over).
// Optional pause support when PAUSE_EN is defined.
// Ports:
//   clk, reset (async, active-high)
//   start, sec_pulse          : one-cycle control pulses
//   score                     : live score from game module
//   game_srst, game_en        : game datapath clear / enable
//   time_left, state          : timer digits value and round phase
//   final_score, high_score   : latched round score and session best
//   new_high                  : this round beat the previous best (OVER only)
//   pause_toggle, paused      : PAUSE_EN only
module game_sequencer #(
    parameter int GAME_SECONDS      = 20,
    parameter int COUNTDOWN_SECONDS = 3,
    parameter int OVER_HOLD_SECONDS = 5,
    parameter int SCORE_BITS        = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  sec_pulse,
    input  logic [SCORE_BITS-1:0] score,
    output logic                  game_srst,
    output logic                  game_en,
    output logic [7:0]            time_left,
    output logic [1:0]            state,
    output logic [SCORE_BITS-1:0] final_score,
    output logic [SCORE_BITS-1:0] high_score,
    output logic                  new_high
`ifdef PAUSE_EN
    ,
    input  logic                  pause_toggle,
    output logic                  paused
`endif
);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        COUNTDOWN = 2'b01,
        PLAY      = 2'b10,
        OVER      = 2'b11
    } state_t;

    localparam logic [7:0] GAME_LEN = 8'(GAME_SECONDS);
    localparam logic [7:0] CD_LEN   = 8'(COUNTDOWN_SECONDS);
    localparam logic [7:0] HOLD_LEN = 8'(OVER_HOLD_SECONDS);

`ifndef PAUSE_EN
    // Without the pause feature the pause register is held at zero
    // and optimised away.
    logic paused;
    logic pause_toggle;
    assign pause_toggle = 1'b0;
`endif

    state_t                cur, nxt;
    logic [7:0]            sec_cnt, sec_n;
    logic [7:0]            hold_cnt, hold_n;
    logic                  srst_n, en_n, nh_n, paused_n;
    logic [SCORE_BITS-1:0] final_n, high_n;

    assign state = cur;

    always_comb begin
        time_left = GAME_LEN;
        unique case (cur)
            IDLE:      time_left = GAME_LEN;
            COUNTDOWN: time_left = sec_cnt;
            PLAY:      time_left = sec_cnt;
            OVER:      time_left = 8'd0;
            default:   time_left = GAME_LEN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur         <= IDLE;
            sec_cnt     <= GAME_LEN;
            hold_cnt    <= 8'd0;
            game_srst   <= 1'b0;
            game_en     <= 1'b0;
            final_score <= '0;
            high_score  <= '0;
            new_high    <= 1'b0;
            paused      <= 1'b0;
        end else begin
            cur         <= nxt;
            sec_cnt     <= sec_n;
            hold_cnt    <= hold_n;
            game_srst   <= srst_n;
            game_en     <= en_n;
            final_score <= final_n;
            high_score  <= high_n;
            new_high    <= nh_n;
            paused      <= paused_n;
        end
    end

    always_comb begin
        nxt      = cur;
        sec_n    = sec_cnt;
        hold_n   = hold_cnt;
        srst_n   = 1'b0;
        en_n     = game_en;
        final_n  = final_score;
        high_n   = high_score;
        nh_n     = new_high;
        paused_n = paused;
        unique case (cur)
            IDLE: begin
                // A coincident tick is dropped; the countdown loads in full.
                if (start) begin
                    nxt    = COUNTDOWN;
                    sec_n  = CD_LEN;
                    srst_n = 1'b1;
                end
            end
            COUNTDOWN: begin
                if (sec_pulse) begin
                    if (sec_cnt == 8'd1) begin
                        nxt   = PLAY;
                        sec_n = GAME_LEN;
                        en_n  = 1'b1;
                    end else begin
                        sec_n = sec_cnt - 8'd1;
                    end
                end
            end
            PLAY: begin
                if (pause_toggle)
                    paused_n = ~paused;
                en_n = ~paused_n;
                // The tick is judged against the pause state before this edge.
                if (sec_pulse && !paused) begin
                    if (sec_cnt == 8'd1) begin
                        nxt      = OVER;
                        en_n     = 1'b0;
                        paused_n = 1'b0;
                        final_n  = score;
                        hold_n   = HOLD_LEN;
                        if (score > high_score) begin
                            high_n = score;
                            nh_n   = 1'b1;
                        end else begin
                            nh_n   = 1'b0;
                        end
                    end else begin
                        sec_n = sec_cnt - 8'd1;
                    end
                end
            end
            OVER: begin
                if (start) begin
                    nxt    = COUNTDOWN;
                    sec_n  = CD_LEN;
                    srst_n = 1'b1;
                    nh_n   = 1'b0;
                end else if (sec_pulse) begin
                    if (hold_cnt == 8'd1) begin
                        nxt  = IDLE;
                        nh_n = 1'b0;
                    end else begin
                        hold_n = hold_cnt - 8'd1;
                    end
                end
            end
            default: nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed round scenarios plus randomized pulses,
// compared against a round-level reference model.
module tb_game_sequencer;

    localparam int GS = 20;
    localparam int CS = 3;
    localparam int HS = 5;

    localparam int PH_IDLE = 0;
    localparam int PH_CD   = 1;
    localparam int PH_PLAY = 2;
    localparam int PH_OVER = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       sec_pulse;
    logic [7:0] score;
    logic       game_srst;
    logic       game_en;
    logic [7:0] time_left;
    logic [1:0] state;
    logic [7:0] final_score;
    logic [7:0] high_score;
    logic       new_high;
    logic       pause_toggle;
    logic       paused;

    int checks = 0;
    int failures = 0;

    // reference model: phase plus seconds remaining in that phase
    int m_phase, m_secs, m_hold, m_final, m_high;
    bit m_srst, m_en, m_nh, m_paused;

    game_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .sec_pulse   (sec_pulse),
        .score       (score),
        .game_srst   (game_srst),
        .game_en     (game_en),
        .time_left   (time_left),
        .state       (state),
        .final_score (final_score),
        .high_score  (high_score),
        .new_high    (new_high)
`ifdef PAUSE_EN
        ,
        .pause_toggle(pause_toggle),
        .paused      (paused)
`endif
    );

`ifndef PAUSE_EN
    assign paused = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase  = PH_IDLE;
        m_secs   = GS;
        m_hold   = 0;
        m_final  = 0;
        m_high   = 0;
        m_srst   = 0;
        m_en     = 0;
        m_nh     = 0;
        m_paused = 0;
    endtask

    task automatic begin_countdown();
        m_phase = PH_CD;
        m_secs  = CS;
        m_srst  = 1;
        m_nh    = 0;
    endtask

    task automatic model_step(input bit st, input bit sp,
                              input int sc, input bit pt);
        bit tick;
        m_srst = 0;
        case (m_phase)
            PH_IDLE: if (st) begin_countdown();
            PH_CD: if (sp) begin
                m_secs--;
                if (m_secs == 0) begin
                    m_phase = PH_PLAY;
                    m_secs  = GS;
                    m_en    = 1;
                end
            end
            PH_PLAY: begin
                tick = sp && !m_paused;
                if (tick && m_secs == 1) begin
                    m_phase  = PH_OVER;
                    m_en     = 0;
                    m_paused = 0;
                    m_final  = sc;
                    m_nh     = sc > m_high;
                    if (m_nh) m_high = sc;
                    m_hold   = HS;
                end else begin
                    if (tick) m_secs--;
`ifdef PAUSE_EN
                    if (pt) m_paused = !m_paused;
`endif
                    m_en = !m_paused;
                end
            end
            default: begin
                if (st) begin_countdown();
                else if (sp) begin
                    m_hold--;
                    if (m_hold == 0) begin
                        m_phase = PH_IDLE;
                        m_nh    = 0;
                    end
                end
            end
        endcase
    endtask

    task automatic compare_all();
        int tl;
        tl = (m_phase == PH_IDLE) ? GS :
             (m_phase == PH_OVER) ? 0 : m_secs;
        check("state", 32'(state), 32'(m_phase));
        check("time_left", 32'(time_left), 32'(tl));
        check("game_srst", 32'(game_srst), 32'(m_srst));
        check("game_en", 32'(game_en), 32'(m_en));
        check("final_score", 32'(final_score), 32'(m_final));
        check("high_score", 32'(high_score), 32'(m_high));
        check("new_high", 32'(new_high), 32'(m_nh));
        check("paused", 32'(paused), 32'(m_paused));
    endtask

    // one clock: drive inputs, model the edge, compare just after it
    task automatic cycle(input bit st, input bit sp, input int sc,
                         input bit pt);
        start        = st;
        sec_pulse    = sp;
        score        = 8'(sc);
        pause_toggle = pt;
        @(posedge clk);
        model_step(st, sp, sc, pt);
        #1;
        compare_all();
        start        = 0;
        sec_pulse    = 0;
        pause_toggle = 0;
    endtask

    task automatic pulses(input int n, input int sc);
        for (int i = 0; i < n; i++) begin
            cycle(0, 1, sc, 0);
            cycle(0, 0, sc, 0);
        end
    endtask

    task automatic do_reset();
        reset = 1;
        #2;
        model_reset();
        compare_all();
        #1;
        reset = 0;
    endtask

    task automatic full_round(input int sc);
        cycle(1, 0, sc, 0);
        pulses(CS + GS + HS, sc);
    endtask

    initial begin
        reset = 0;
        start = 0;
        sec_pulse = 0;
        score = 0;
        pause_toggle = 0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        check("rst_state", 32'(state), 0);
        check("rst_tl", 32'(time_left), GS);
        check("rst_high", 32'(high_score), 0);

        // round 1: start, countdown with stray start, play with score 12
        cycle(1, 0, 0, 0);
        check("srst_pulse", 32'(game_srst), 1);
        check("cd_tl", 32'(time_left), 3);
        cycle(0, 0, 0, 0);
        check("srst_once", 32'(game_srst), 0);
        cycle(0, 1, 0, 0);
        check("cd_tl2", 32'(time_left), 2);
        cycle(1, 0, 0, 0);
        check("cd_start_ign", 32'(time_left), 2);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        check("play_state", 32'(state), PH_PLAY);
        check("play_en", 32'(game_en), 1);
        check("play_tl", 32'(time_left), GS);
        pulses(10, 12);
        cycle(1, 0, 12, 0);
        check("play_start_ign", 32'(time_left), 10);
        pulses(10, 12);
        check("over_state", 32'(state), PH_OVER);
        check("over_final", 32'(final_score), 12);
        check("over_high", 32'(high_score), 12);
        check("over_nh", 32'(new_high), 1);
        check("over_tl", 32'(time_left), 0);
        pulses(HS, 12);
        check("idle_back", 32'(state), PH_IDLE);
        check("idle_nh", 32'(new_high), 0);

        // round 2 ties, round 3 lower and restarted from OVER
        full_round(12);
        check("tie_nh", 32'(new_high), 0);
        check("tie_final", 32'(final_score), 12);
        cycle(1, 0, 9, 0);
        pulses(CS + GS, 9);
        check("low_final", 32'(final_score), 9);
        check("low_high", 32'(high_score), 12);
        check("low_nh", 32'(new_high), 0);
        pulses(HS - 1, 9);
        cycle(1, 1, 9, 0);
        check("over_restart", 32'(state), PH_CD);
        check("over_restart_tl", 32'(time_left), CS);
        check("over_restart_srst", 32'(game_srst), 1);

        // into play, reset at 7 seconds left
        pulses(CS + GS - 7, 5);
        check("pre_rst_tl", 32'(time_left), 7);
        do_reset();
        check("mid_rst_high", 32'(high_score), 0);
        check("mid_rst_en", 32'(game_en), 0);

        // start coincident with tick in IDLE
        cycle(1, 1, 0, 0);
        check("idle_tick_ign", 32'(time_left), CS);
        pulses(CS, 0);

`ifdef PAUSE_EN
        pulses(GS - 10, 3);
        cycle(0, 0, 3, 1);
        check("pause_on", 32'(paused), 1);
        pulses(4, 3);
        check("pause_tl", 32'(time_left), 10);
        check("pause_en", 32'(game_en), 0);
        cycle(0, 0, 3, 1);
        check("unpause_en", 32'(game_en), 1);
        pulses(1, 3);
        check("resume_tl", 32'(time_left), 9);
`endif

        // randomized phase
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 699) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 29) == 0,
                      $urandom_range(0, 2) == 0,
                      int'($urandom_range(0, 255)),
                      $urandom_range(0, 19) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
